// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC loop controller.
// Op-codes are common to this controller and the fabric mapping.
package mac_ctrl_pkg;

  localparam int ELEM_BYTES_DFLT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_BR     = 4'd1,
    OP_CONST  = 4'd2,
    OP_ICMP   = 4'd3,
    OP_INPUT  = 4'd4,
    OP_LOAD   = 4'd5,
    OP_MUL    = 4'd6,
    OP_OUTPUT = 4'd7,
    OP_PHI    = 4'd8
  } alu_op_t;

endpackage

// File: rtl/mac_loop_ctrl_ptr_gen.sv
// Dual address pointer: load both bases, or step both by one element.
// Addition wraps modulo 2^ADDR_WIDTH.
module mac_ptr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int STRIDE     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  output logic [ADDR_WIDTH-1:0] ptr_a,
  output logic [ADDR_WIDTH-1:0] ptr_b
);

  localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(STRIDE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_a <= '0;
      ptr_b <= '0;
    end else if (load) begin
      ptr_a <= base_a;
      ptr_b <= base_b;
    end else if (step) begin
      ptr_a <= ptr_a + INC;
      ptr_b <= ptr_b + INC;
    end
  end

endmodule

// File: rtl/mac_loop_ctrl.sv
// Dot-product loop sequencer on one shared memory read port.
// Handshake outputs decode the state register directly.
module mac_loop_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int ELEM_BYTES = ELEM_BYTES_DFLT
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [CNT_WIDTH-1:0]  trip_count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [WIDTH-1:0]      result,
  output logic [CNT_WIDTH-1:0]  iter_idx
);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  i_q, trip_q, i_nxt;
  logic [WIDTH-1:0]      acc_q, a_q, b_q, prod;
  logic [ADDR_WIDTH-1:0] ptr_a, ptr_b;
  logic                  ptr_load, ptr_step;

  assign i_nxt = i_q + 1'b1;
  assign prod  = a_q * b_q;

  mac_ptr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRIDE     (ELEM_BYTES)
  ) u_ptr (
    .clk    (CLK),
    .rst_n  (RESETn),
    .load   (ptr_load),
    .step   (ptr_step),
    .base_a (base_a),
    .base_b (base_b),
    .ptr_a  (ptr_a),
    .ptr_b  (ptr_b)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_load = 1'b0;
    ptr_step = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_load = 1'b1;
          state_d  = (trip_count == '0) ? S_OUT : S_LOAD_A;
        end
      end
      S_LOAD_A: if (mem_ack) state_d = S_LOAD_B;
      S_LOAD_B: if (mem_ack) state_d = S_MAC;
      S_MAC: begin
        ptr_step = 1'b1;
        state_d  = (i_nxt == trip_q) ? S_OUT : S_LOAD_A;
      end
      S_OUT:  if (result_ready) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      i_q    <= '0;
      trip_q <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        trip_q <= trip_count;
        i_q    <= '0;
        acc_q  <= '0;
      end
      if (state_q == S_LOAD_A && mem_ack) a_q <= mem_rdata;
      if (state_q == S_LOAD_B && mem_ack) b_q <= mem_rdata;
      if (state_q == S_MAC) begin
        acc_q <= acc_q + prod;
        i_q   <= i_nxt;
      end
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign mem_req      = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign result_valid = (state_q == S_OUT);
  assign result       = acc_q;
  assign iter_idx     = i_q;

  always_comb begin
    mem_addr = '0;
    if (state_q == S_LOAD_A) mem_addr = ptr_a;
    if (state_q == S_LOAD_B) mem_addr = ptr_b;
  end

endmodule

// File: tb/tb_mac_loop_ctrl.sv
// Directed bench for mac_loop_ctrl with a word memory model
// that answers requests after a programmable number of wait cycles.
module tb_mac_loop_ctrl;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_a = '0;
  logic [31:0] base_b = '0;
  logic [15:0] trip_count = '0;
  logic        busy, done, mem_req, result_valid;
  logic [31:0] mem_addr, result;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        result_ready = 1'b0;
  logic [15:0] iter_idx;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [64];
  int          max_wait = 0;
  bit          stall = 1'b0;
  int          done_cnt = 0;
  int          req_seen = 0;
  int          unstable = 0;
  logic [31:0] addr_log [$];

  mac_loop_ctrl dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .start        (start),
    .base_a       (base_a),
    .base_b       (base_b),
    .trip_count   (trip_count),
    .busy         (busy),
    .done         (done),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .iter_idx     (iter_idx)
  );

  initial forever #5 CLK = ~CLK;

  // memory responder and observers
  initial begin : mon
    int          wait_left;
    bit          pend;
    logic [31:0] last_addr;
    wait_left = 0;
    pend = 1'b0;
    last_addr = '0;
    forever begin
      @(posedge CLK);
      if (mem_req && mem_ack) begin
        addr_log.push_back(mem_addr);
        pend = 1'b0;
        wait_left = (max_wait == 0) ? 0 : int'($urandom_range(max_wait, 0));
      end
      @(negedge CLK);
      if (done) done_cnt++;
      if (mem_req) begin
        req_seen++;
        if (pend && mem_addr !== last_addr) unstable++;
        pend = 1'b1;
        last_addr = mem_addr;
      end else begin
        pend = 1'b0;
      end
      mem_ack = 1'b0;
      if (mem_req && !stall) begin
        if (wait_left == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr[7:2]];
        end else begin
          wait_left--;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] ba, input logic [31:0] bb,
                        input logic [15:0] trip);
    @(negedge CLK);
    base_a = ba;
    base_b = bb;
    trip_count = trip;
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!result_valid && lat < 300) begin
      @(posedge CLK);
      #1 lat++;
    end
  endtask

  task automatic wait_load_b(input logic [31:0] bb, output bit found);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(posedge CLK);
      #1 if (mem_req && mem_addr === bb) found = 1'b1;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge CLK);
    result_ready = 1'b1;
    @(posedge CLK);
    #1 check({tag, "_done_hi"}, 32'(done), 32'd1);
    result_ready = 1'b0;
    @(posedge CLK);
    #1 check({tag, "_done_lo"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin : main
    int          lat, s, d0, r0;
    bit          found;
    logic [31:0] exp_addr [8];
    exp_addr = '{32'h00, 32'h24, 32'h04, 32'h28,
                 32'h08, 32'h2C, 32'h0C, 32'h30};
    for (int k = 0; k < 64; k++) mem[k] = '0;
    mem[0] = 1;  mem[1] = 2;  mem[2] = 3;  mem[3] = 4;
    mem[9] = 5;  mem[10] = 6; mem[11] = 7; mem[12] = 8;
    mem[16] = 32'h0001_0000; mem[17] = 32'hFFFF_FFFF;
    mem[32] = 32'h0001_0000; mem[33] = 32'h0000_0002;

    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_result", result, 0);
    check("rst_iter", 32'(iter_idx), 0);
    repeat (2) @(posedge CLK);
    #2 RESETn = 1'b1;

    // nominal
    s = addr_log.size();
    d0 = done_cnt;
    launch(32'h00, 32'h24, 16'd4);
    wait_valid(lat);
    check("nom_latency", 32'(lat), 13);
    check("nom_result", result, 70);
    check("nom_iter", 32'(iter_idx), 4);
    check("nom_naddr", 32'(addr_log.size() - s), 8);
    for (int k = 0; k < 8; k++)
      if (s + k < addr_log.size())
        check($sformatf("nom_addr%0d", k), addr_log[s+k], exp_addr[k]);
    handshake("nom");
    check("nom_done_cnt", 32'(done_cnt - d0), 1);

    // wait states
    max_wait = 3;
    launch(32'h00, 32'h24, 16'd4);
    wait_valid(lat);
    check("ws_valid", 32'(result_valid), 1);
    check("ws_result", result, 70);
    check("ws_stable", 32'(unstable), 0);
    handshake("ws");
    max_wait = 0;

    // zero trip
    r0 = req_seen;
    launch(32'h00, 32'h24, 16'd0);
    wait_valid(lat);
    check("zt_latency", 32'(lat), 1);
    check("zt_result", result, 0);
    handshake("zt");
    check("zt_noreq", 32'(req_seen - r0), 0);

    // overflow wrap
    launch(32'h40, 32'h80, 16'd2);
    wait_valid(lat);
    check("ov_latency", 32'(lat), 7);
    check("ov_result", result, 32'hFFFF_FFFE);
    handshake("ov");

    // backpressure and start while busy
    d0 = done_cnt;
    launch(32'h00, 32'h24, 16'd4);
    wait_load_b(32'h24, found);
    check("bp_found_lb", 32'(found), 1);
    base_a = 32'h40;
    trip_count = 16'd1;
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid%0d", c), 32'(result_valid), 1);
      check($sformatf("bp_result%0d", c), result, 70);
      if (c == 2) start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
    end
    handshake("bp");
    repeat (3) @(posedge CLK);
    #1 check("bp_stay_idle", 32'(busy), 0);
    check("bp_done_cnt", 32'(done_cnt - d0), 1);

    // reset mid-run
    stall = 1'b1;
    launch(32'h00, 32'h24, 16'd4);
    @(posedge CLK);
    #1 check("rm_in_load_a", 32'(mem_req), 1);
    stall = 1'b0;
    @(negedge CLK);
    stall = 1'b1;
    @(posedge CLK);
    #1 check("rm_in_load_b", mem_addr, 32'h24);
    #2 RESETn = 1'b0;
    #1;
    check("rm_req", 32'(mem_req), 0);
    check("rm_busy", 32'(busy), 0);
    check("rm_valid", 32'(result_valid), 0);
    check("rm_result", result, 0);
    @(negedge CLK);
    stall = 1'b0;
    RESETn = 1'b1;
    mem[0] = 3;
    mem[9] = 9;
    launch(32'h00, 32'h24, 16'd1);
    wait_valid(lat);
    check("rm_latency", 32'(lat), 4);
    check("rm_result27", result, 27);
    handshake("rm");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_loop_ctrl.md
Name: mac_loop_ctrl

Overview:
Sequencer that executes the dot-product (multiply-accumulate) loop kernel on a single shared memory read port.
- Loop body per iteration i: load a[i], load b[i], acc += a*b, i += 1; exit when i equals the trip count.
- Owns the loop index, both address pointers, the accumulator, the memory request handshake and the result handshake.
- Sits between the host/config side (start, bases, trip count) and the fabric memory port.

Parameters:
WIDTH, 32, data/accumulator width
ADDR_WIDTH, 32, memory address width
CNT_WIDTH, 16, loop counter / trip count width
ELEM_BYTES, 4, address stride per element (the kernel's data size)

Ports:
CLK  in  1  clock, all state on rising edge
RESETn  in  1  asynchronous active-low reset
start  in  1  launch request, sampled only in IDLE
base_a  in  ADDR_WIDTH  base address of array a, captured at start
base_b  in  ADDR_WIDTH  base address of array b, captured at start
trip_count  in  CNT_WIDTH  iteration count, captured at start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the result handshake completes
mem_req  out  1  memory read request
mem_addr  out  ADDR_WIDTH  read address, valid while mem_req is high
mem_ack  in  1  read data valid and request accepted
mem_rdata  in  WIDTH  read data, sampled when mem_req and mem_ack are both high
result_valid  out  1  accumulator result available
result_ready  in  1  consumer accepts the result
result  out  WIDTH  final accumulator value
iter_idx  out  CNT_WIDTH  current loop index (debug/observe)

Behaviour:
- Clock/reset: CLK is the single clock. Reset is RESETn, asynchronous, active-low.
- While RESETn is low, all outputs and registers are 0 and the state is IDLE. mem_req falls immediately, without waiting for a clock edge.
- States and transitions:
  - IDLE: on start, capture the inputs; set ptr_a=base_a, ptr_b=base_b, i=0, acc=0. If trip_count==0, go to OUT; otherwise go to LOAD_A.
  - LOAD_A: mem_req=1, mem_addr=ptr_a. On mem_ack, capture a_reg=mem_rdata and go to LOAD_B.
  - LOAD_B: mem_req=1, mem_addr=ptr_b. On mem_ack, capture b_reg and go to MAC.
  - MAC: acc <= acc + low WIDTH bits of (a_reg*b_reg), wrapping modulo 2^WIDTH. Update i <= i+1, ptr_a += ELEM_BYTES, ptr_b += ELEM_BYTES. If i+1 == trip_count (equality compare), go to OUT; otherwise go to LOAD_A.
  - OUT: result_valid=1, result=acc. On result_ready, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Memory handshake:
  - mem_req and mem_addr are registered-state driven and held stable until mem_ack.
  - mem_ack while mem_req is low is ignored.
  - Zero-wait ack (same cycle as req) is legal.
- Result handshake: result_valid and result are held stable until result_ready. result_ready while result_valid is low is ignored.
- Latency: start sampled at edge k. With zero-wait memory, the first mem_req is high in cycle k+1 and result_valid rises in cycle k+1+3*trip_count. Each memory wait cycle adds 1.
- Wrap-around:
  - Pointers wrap modulo 2^ADDR_WIDTH.
  - i never wraps in practice, since exit happens at trip_count ≤ 2^CNT_WIDTH-1.
  - Pointers are updated incrementally; no multiplier is used for addresses.
- start while busy is ignored, including in the DONE cycle.
- Reset mid-operation aborts the loop; no partial result is produced.
- result keeps its last value after DONE and until the next start. result_valid is low in IDLE.

Decomposition:
- Shared package mac_ctrl_pkg holds:
  - the state enum (IDLE, LOAD_A, LOAD_B, MAC, OUT, DONE);
  - the default ELEM_BYTES;
  - the ALU op-code constants (add, br, const, icmp, input, load, mul, output, phi = 0..8) so this controller and the fabric mapping share one definition.
- One sub-module: mac_ptr_gen, a dual address pointer with load(base) and step(ELEM_BYTES) controls.
- FSM, counter and accumulator stay in the top.

Test Plan:
- Nominal run: trip=4, base_a=0x00, base_b=0x24, a=[1,2,3,4], b=[5,6,7,8], zero-wait ack.
  - mem_addr sequence must be 0x00,0x24,0x04,0x28,0x08,0x2C,0x0C,0x30.
  - result=70, result_valid in cycle k+13, done one cycle after the handshake.
- Wait states: same data as nominal, mem_ack delayed 0–3 random cycles per request.
  - mem_addr must stay stable while mem_req is high; result=70.
- Zero trip: trip=0 → no mem_req ever asserted; result=0, result_valid in cycle k+1.
- Overflow wrap: trip=2, a=[0x10000,0xFFFFFFFF], b=[0x10000,2].
  - Product terms must be 0x0 and 0xFFFFFFFE; result=0xFFFFFFFE.
- Backpressure and start-while-busy: result_ready held low 5 cycles, start pulsed during LOAD_B and during OUT.
  - result_valid and result must be held; the start pulses are ignored; exactly one done pulse.
- Reset mid-run: RESETn low during LOAD_B with mem_req high.
  - mem_req, busy and result_valid must go 0 before the next edge.
  - After release, start with trip=1, a=[3], b=[9] → result=27.
